// File: rtl/ace_snoop_initiator.sv
// Interconnect-side ACE snoop initiator: issues one snoop on AC, collects the CR
// response and an optional CD cache line, and returns them as a single result.
module ace_snoop_initiator #(
  parameter int WIDTH_A     = 32,
  parameter int WIDTH_D     = 32,
  parameter int LINE_WORDS  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [WIDTH_A-1:0]            req_addr,
  input  logic [3:0]                    req_snoop,
  input  logic [2:0]                    req_prot,
  output logic                          AC_VALID,
  input  logic                          AC_READY,
  output logic [WIDTH_A-1:0]            AC_ADDR,
  output logic [3:0]                    AC_SNOOP,
  output logic [2:0]                    AC_PROT,
  input  logic                          CR_VALID,
  output logic                          CR_READY,
  input  logic [4:0]                    CR_RESP,
  input  logic                          CD_VALID,
  output logic                          CD_READY,
  input  logic                          CD_LAST,
  input  logic [WIDTH_D-1:0]            CD_DATA,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [4:0]                    rsp_cr_resp,
  output logic                          rsp_has_data,
  output logic [LINE_WORDS*WIDTH_D-1:0] rsp_line,
  output logic                          rsp_err,
  output logic                          rsp_timeout
);

  localparam int BCW = $clog2(LINE_WORDS + 1);
  localparam int TCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(LINE_WORDS - 1);
  localparam logic [BCW-1:0] BEAT_FULL  = BCW'(LINE_WORDS);
  localparam logic [TCW-1:0] WAIT_LIM   = TCW'(TIMEOUT_CYC);
  localparam logic [TCW-1:0] WAIT_MAX   = '1;
  localparam bit             TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AC,
    S_CR,
    S_CD,
    S_RSP
  } state_t;

  state_t                          state_q, state_d;
  logic                            req_ready_q, req_ready_d;
  logic                            ac_valid_q, ac_valid_d;
  logic [WIDTH_A-1:0]              ac_addr_q, ac_addr_d;
  logic [3:0]                      ac_snoop_q, ac_snoop_d;
  logic [2:0]                      ac_prot_q, ac_prot_d;
  logic                            cr_ready_q, cr_ready_d;
  logic                            cd_ready_q, cd_ready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [4:0]                      rsp_cr_resp_q, rsp_cr_resp_d;
  logic                            rsp_has_data_q, rsp_has_data_d;
  logic [LINE_WORDS*WIDTH_D-1:0]   rsp_line_q, rsp_line_d;
  logic                            rsp_err_q, rsp_err_d;
  logic                            rsp_timeout_q, rsp_timeout_d;
  logic [TCW-1:0]                  wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0]                  beat_cnt_q, beat_cnt_d;

  always_comb begin
    state_d        = state_q;
    ac_addr_d      = ac_addr_q;
    ac_snoop_d     = ac_snoop_q;
    ac_prot_d      = ac_prot_q;
    rsp_cr_resp_d  = rsp_cr_resp_q;
    rsp_has_data_d = rsp_has_data_q;
    rsp_line_d     = rsp_line_q;
    rsp_err_d      = rsp_err_q;
    rsp_timeout_d  = rsp_timeout_q;
    wait_cnt_d     = wait_cnt_q;
    beat_cnt_d     = beat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          ac_addr_d      = req_addr;
          ac_snoop_d     = req_snoop;
          ac_prot_d      = req_prot;
          rsp_cr_resp_d  = '0;
          rsp_has_data_d = 1'b0;
          rsp_line_d     = '0;
          rsp_err_d      = 1'b0;
          rsp_timeout_d  = 1'b0;
          wait_cnt_d     = '0;
          beat_cnt_d     = '0;
          state_d        = S_AC;
        end
      end

      S_AC: begin
        if (ac_valid_q && AC_READY) begin
          state_d = S_CR;
        end
      end

      S_CR: begin
        // A response arriving in the timeout cycle takes priority over the timeout.
        if (CR_VALID && cr_ready_q) begin
          rsp_cr_resp_d = CR_RESP;
          if (CR_RESP[1]) begin
            rsp_err_d = 1'b1;
          end
          if (CR_RESP[0]) begin
            rsp_has_data_d = 1'b1;
            state_d        = S_CD;
          end else begin
            state_d = S_RSP;
          end
        end else if (TIMEOUT_EN && (wait_cnt_q + TCW'(1) == WAIT_LIM)) begin
          rsp_timeout_d = 1'b1;
          rsp_cr_resp_d = '0;
          state_d       = S_RSP;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + TCW'(1);
        end
      end

      S_CD: begin
        if (CD_VALID && cd_ready_q) begin
          if (beat_cnt_q < BEAT_FULL) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
              if (beat_cnt_q == BCW'(i)) begin
                rsp_line_d[i*WIDTH_D +: WIDTH_D] = CD_DATA;
              end
            end
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end else begin
            rsp_err_d = 1'b1;
          end
          // beat_cnt_q still counts the beats before this one
          if (CD_LAST) begin
            if (beat_cnt_q != BEAT_LAST) begin
              rsp_err_d = 1'b1;
            end
            state_d = S_RSP;
          end
        end
      end

      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered decodes of the upcoming state.
    req_ready_d = (state_d == S_IDLE);
    ac_valid_d  = (state_d == S_AC);
    cr_ready_d  = (state_d == S_CR);
    cd_ready_d  = (state_d == S_CD);
    rsp_valid_d = (state_d == S_RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b0;
      ac_valid_q     <= 1'b0;
      ac_addr_q      <= '0;
      ac_snoop_q     <= '0;
      ac_prot_q      <= '0;
      cr_ready_q     <= 1'b0;
      cd_ready_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_cr_resp_q  <= '0;
      rsp_has_data_q <= 1'b0;
      rsp_line_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      wait_cnt_q     <= '0;
      beat_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      ac_valid_q     <= ac_valid_d;
      ac_addr_q      <= ac_addr_d;
      ac_snoop_q     <= ac_snoop_d;
      ac_prot_q      <= ac_prot_d;
      cr_ready_q     <= cr_ready_d;
      cd_ready_q     <= cd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_cr_resp_q  <= rsp_cr_resp_d;
      rsp_has_data_q <= rsp_has_data_d;
      rsp_line_q     <= rsp_line_d;
      rsp_err_q      <= rsp_err_d;
      rsp_timeout_q  <= rsp_timeout_d;
      wait_cnt_q     <= wait_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign AC_VALID     = ac_valid_q;
  assign AC_ADDR      = ac_addr_q;
  assign AC_SNOOP     = ac_snoop_q;
  assign AC_PROT      = ac_prot_q;
  assign CR_READY     = cr_ready_q;
  assign CD_READY     = cd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cr_resp  = rsp_cr_resp_q;
  assign rsp_has_data = rsp_has_data_q;
  assign rsp_line     = rsp_line_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Bench for ace_snoop_initiator: directed and random snoop transactions checked
// against a transaction-level model of the expected result.
module tb_ace_snoop_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int TO = 8;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
  logic [3:0]           req_snoop;
  logic [2:0]           req_prot;
  logic                 AC_VALID;
  logic                 AC_READY;
  logic [AW-1:0]        AC_ADDR;
  logic [3:0]           AC_SNOOP;
  logic [2:0]           AC_PROT;
  logic                 CR_VALID;
  logic                 CR_READY;
  logic [4:0]           CR_RESP;
  logic                 CD_VALID;
  logic                 CD_READY;
  logic                 CD_LAST;
  logic [DW-1:0]        CD_DATA;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [4:0]           rsp_cr_resp;
  logic                 rsp_has_data;
  logic [LW*DW-1:0]     rsp_line;
  logic                 rsp_err;
  logic                 rsp_timeout;

  ace_snoop_initiator #(
    .WIDTH_A(AW), .WIDTH_D(DW), .LINE_WORDS(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_snoop(req_snoop), .req_prot(req_prot),
    .AC_VALID(AC_VALID), .AC_READY(AC_READY), .AC_ADDR(AC_ADDR),
    .AC_SNOOP(AC_SNOOP), .AC_PROT(AC_PROT),
    .CR_VALID(CR_VALID), .CR_READY(CR_READY), .CR_RESP(CR_RESP),
    .CD_VALID(CD_VALID), .CD_READY(CD_READY), .CD_LAST(CD_LAST), .CD_DATA(CD_DATA),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cr_resp(rsp_cr_resp),
    .rsp_has_data(rsp_has_data), .rsp_line(rsp_line), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]        addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
    int                   ac_dly;
    int                   cr_dly;   // CR cycles without CR_VALID before it is driven
    logic [4:0]           resp;
    int                   nbeats;
    logic [7:0][DW-1:0]   data;
    int                   rsp_dly;
    bit                   keep_req;
  } txn_t;

  typedef struct packed {
    logic [4:0]       cr;
    logic             has;
    logic [LW*DW-1:0] line;
    logic             err;
    logic             to;
  } exp_t;

  int   checks;
  int   errors;
  exp_t sb[$];

  // monitor bookkeeping
  bit            busy, p_acc, p_acwait, p_done;
  logic [AW-1:0] ea;
  logic [3:0]    es;
  logic [2:0]    ep;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic abort(input string nm);
    checks++;
    errors++;
    $display("FAIL %s bounded wait expired", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Expected result of a transaction, from the snoop rules alone.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    e = '0;
    if (t.cr_dly >= TO) begin
      e.to = 1'b1;
      return e;
    end
    e.cr  = t.resp;
    e.err = t.resp[1];
    if (t.resp[0]) begin
      e.has = 1'b1;
      for (int k = 0; k < t.nbeats; k++) begin
        if (k < LW) e.line[k*DW +: DW] = t.data[k];
        else        e.err = 1'b1;
      end
      if (t.nbeats != LW) e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic txn_t base_txn();
    txn_t t;
    t.addr = '0; t.snoop = '0; t.prot = '0; t.ac_dly = 0; t.cr_dly = 0;
    t.resp = '0; t.nbeats = 0; t.data = '0; t.rsp_dly = 0; t.keep_req = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    t = base_txn();
    t.addr    = $urandom;
    t.snoop   = 4'($urandom_range(0, 15));
    t.prot    = 3'($urandom_range(0, 7));
    t.ac_dly  = $urandom_range(0, 3);
    r         = $urandom_range(0, 9);
    t.cr_dly  = (r < 6) ? (r % 3) : r;
    t.resp    = 5'($urandom);
    t.nbeats  = ($urandom_range(0, 4) != 0) ? LW : $urandom_range(1, 6);
    for (int k = 0; k < 8; k++) t.data[k] = $urandom;
    t.rsp_dly = $urandom_range(0, 3);
    t.keep_req = 1'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic bit sig_sel(input int which);
    case (which)
      0:       return req_ready;
      1:       return AC_VALID;
      2:       return CR_READY;
      3:       return CD_READY;
      default: return rsp_valid;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int which, input string nm);
    int n;
    n = 0;
    while (!sig_sel(which)) begin
      step();
      n++;
      if (n > 100) abort(nm);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 160'({req_ready, AC_VALID, CR_READY, CD_READY, rsp_valid}), 160'(0));
    check({tag, "_ac"}, 160'({AC_ADDR, AC_SNOOP, AC_PROT}), 160'(0));
    check({tag, "_flags"}, 160'({rsp_cr_resp, rsp_has_data, rsp_err, rsp_timeout}), 160'(0));
    check({tag, "_line"}, 160'(rsp_line), 160'(0));
  endtask

  // Per-cycle compare process; inputs only change just after posedge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; p_acc = 0; p_acwait = 0; p_done = 0;
        continue;
      end
      if (busy)     check("req_ready_busy", 160'(req_ready), 160'(0));
      if (p_acc)    check("ac_latency", 160'(AC_VALID), 160'(1));
      if (p_acwait) check("ac_hold", 160'(AC_VALID), 160'(1));
      if (AC_VALID) check("ac_payload", 160'({AC_ADDR, AC_SNOOP, AC_PROT}), 160'({ea, es, ep}));
      check("one_state", 160'($countones({req_ready, AC_VALID, CR_READY, CD_READY, rsp_valid}) <= 1),
            160'(1));
      if (p_done)   check("rsp_latency", 160'(rsp_valid), 160'(1));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 160'(rsp_valid), 160'(0));
        end else begin
          e = sb[0];
          check("rsp_cr_resp", 160'(rsp_cr_resp), 160'(e.cr));
          check("rsp_has_data", 160'(rsp_has_data), 160'(e.has));
          check("rsp_line", 160'(rsp_line), 160'(e.line));
          check("rsp_err", 160'(rsp_err), 160'(e.err));
          check("rsp_timeout", 160'(rsp_timeout), 160'(e.to));
        end
      end
      p_acc = req_valid && req_ready;
      if (p_acc) begin
        ea = req_addr; es = req_snoop; ep = req_prot;
        busy = 1;
      end
      if (rsp_valid && rsp_ready) begin
        busy = 0;
        if (sb.size() != 0) void'(sb.pop_front());
      end
      p_acwait = AC_VALID && !AC_READY;
      p_done   = (CR_VALID && CR_READY && !CR_RESP[0]) || (CD_VALID && CD_READY && CD_LAST);
    end
  endtask

  task automatic run_txn(input txn_t t, input bit rst_in_cd);
    if (!rst_in_cd) sb.push_back(model(t));
    req_addr  = t.addr;
    req_snoop = t.snoop;
    req_prot  = t.prot;
    req_valid = 1'b1;
    wait_sig(0, "wait_req_ready");
    step();
    req_valid = t.keep_req;
    req_addr  = $urandom;
    req_snoop = 4'($urandom);
    req_prot  = 3'($urandom);
    wait_sig(1, "wait_ac_valid");
    repeat (t.ac_dly) step();
    AC_READY = 1'b1;
    step();
    AC_READY = 1'b0;
    wait_sig(2, "wait_cr_ready");
    for (int k = 0; k < t.cr_dly && CR_READY; k++) begin
      CR_RESP = 5'($urandom);
      step();
    end
    if (CR_READY) begin
      CR_VALID = 1'b1;
      CR_RESP  = t.resp;
      step();
      CR_VALID = 1'b0;
      CR_RESP  = 5'($urandom);
      if (t.resp[0]) begin
        wait_sig(3, "wait_cd_ready");
        for (int b = 0; b < t.nbeats; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            CD_DATA = $urandom;
            step();
          end
          CD_VALID = 1'b1;
          CD_DATA  = t.data[b];
          CD_LAST  = (b == t.nbeats - 1);
          step();
          CD_VALID = 1'b0;
          CD_LAST  = 1'b0;
          if (rst_in_cd && b == 1) begin
            rst = 1'b1;
            step();
            check_zero("mid_reset");
            rst = 1'b0;
            req_valid = 1'b0;
            return;
          end
        end
      end
    end
    wait_sig(4, "wait_rsp_valid");
    repeat (t.rsp_dly) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    txn_t t;
    exp_t e;
    checks = 0; errors = 0;
    busy = 0; p_acc = 0; p_acwait = 0; p_done = 0;
    ea = '0; es = '0; ep = '0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_snoop = '0; req_prot = '0;
    AC_READY = 1'b0; CR_VALID = 1'b0; CR_RESP = '0;
    CD_VALID = 1'b0; CD_LAST = 1'b0; CD_DATA = '0; rsp_ready = 1'b0;
    fork
      monitor();
      begin
        repeat (60000) @(posedge clk);
        abort("watchdog");
      end
    join_none

    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check("idle_ready", 160'(req_ready), 160'(1));

    // ReadShared, no data
    t = base_txn();
    t.addr = 32'h1000_0040; t.snoop = 4'h1; t.prot = 3'h2; t.ac_dly = 2; t.cr_dly = 1;
    t.resp = 5'b01000;
    e = model(t);
    check("pin_nodata", 160'(e), 160'({5'b01000, 1'b0, 128'h0, 1'b0, 1'b0}));
    run_txn(t, 1'b0);

    // full line
    t = base_txn();
    t.addr = 32'h2000_0080; t.resp = 5'b00101; t.nbeats = 4;
    for (int k = 0; k < 4; k++) t.data[k] = 32'hA0 + 32'(k);
    e = model(t);
    check("pin_line", 160'(e.line), 160'(128'h000000A3_000000A2_000000A1_000000A0));
    check("pin_line_flags", 160'({e.has, e.err}), 160'(2'b10));
    run_txn(t, 1'b0);

    // early LAST on beat 2
    t = base_txn();
    t.resp = 5'b00001; t.nbeats = 2; t.data[0] = 32'hB0; t.data[1] = 32'hB1;
    e = model(t);
    check("pin_short", 160'({e.err, e.line}), 160'({1'b1, 128'h00000000_00000000_000000B1_000000B0}));
    run_txn(t, 1'b0);

    // five beats, fifth dropped
    t = base_txn();
    t.resp = 5'b00001; t.nbeats = 5;
    for (int k = 0; k < 5; k++) t.data[k] = 32'hC0 + 32'(k);
    e = model(t);
    check("pin_long", 160'({e.err, e.line}), 160'({1'b1, 128'h000000C3_000000C2_000000C1_000000C0}));
    run_txn(t, 1'b0);

    // timeout, then a response in the last permitted cycle
    t = base_txn();
    t.resp = 5'b10011; t.cr_dly = 8;
    e = model(t);
    check("pin_timeout", 160'({e.to, e.cr, e.err}), 160'({1'b1, 5'b0, 1'b0}));
    run_txn(t, 1'b0);
    t.cr_dly = 7; t.resp = 5'b10010;
    e = model(t);
    check("pin_no_timeout", 160'({e.to, e.cr, e.err}), 160'({1'b0, 5'b10010, 1'b1}));
    run_txn(t, 1'b0);

    // reset during CD, then a clean transaction
    t = base_txn();
    t.resp = 5'b00001; t.nbeats = 4; t.data[0] = 32'hD0; t.data[1] = 32'hD1;
    run_txn(t, 1'b1);
    step();
    check("post_reset_ready", 160'(req_ready), 160'(1));
    run_txn(rand_txn(), 1'b0);

    // slow consumer with a pending request
    t = rand_txn();
    t.rsp_dly = 5; t.keep_req = 1'b1;
    run_txn(t, 1'b0);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) step();
      run_txn(rand_txn(), 1'b0);
    end
    repeat (3) step();
    check("scoreboard_drained", 160'(sb.size()), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
